instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Program-counter and opcode-fetch stage that sits directly upstream of the 4096-byte CHIP-8 memory's instruction port. It drives byte addresses into memory, assembles two consecutive bytes into a 16-bit big-endian opcode, and hands that opcode to the decode/execute stage over a valid/ready handshake. It also applies control-flow dispositions (jump, call, return, skip) using an internal 16-entry return stack.

## Interface
Parameters:
- RESET_PC, 12'h200: PC value after reset.
- STACK_DEPTH, 16: return-stack entries. Fixed at 16; the stack pointer is 5 bits wide.

Ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- resetN  in  1  reset, synchronous and active-low; sampled on the rising edge of clock.
- fetch_addr  out  12  byte address to memory.
- fetch_byte  in  8  memory data; equals mem[fetch_addr as presented the previous cycle].
- opcode  out  16  assembled opcode; {mem[pc], mem[pc+1]}.
- opcode_valid  out  1  opcode is held and stable.
- opcode_ready  in  1  consumer accepts the opcode.
- ctl_jump  in  1  disposition: PC <= ctl_target.
- ctl_call  in  1  disposition: push pc+2, then PC <= ctl_target.
- ctl_ret  in  1  disposition: PC <= popped value.
- ctl_skip  in  1  disposition: PC <= pc+4.
- ctl_target  in  12  jump/call destination.
- pc  out  12  address of the current or next opcode.
- sp  out  5  stack occupancy, 0..16.
- fault  out  1  sticky stack overflow/underflow flag.

## Operation
- FSM states: S_HI, S_LO, S_CAP, S_HOLD, S_HALT.
- S_HI: fetch_addr=pc; go to S_LO.
- S_LO: fetch_addr=pc+1; capture fetch_byte into opcode[15:8]; go to S_CAP.
- S_CAP: capture fetch_byte into opcode[7:0]; go to S_HOLD.
- S_HOLD: opcode_valid=1. opcode and pc hold until a handshake (opcode_valid & opcode_ready). On a handshake, compute the next pc and go to S_HI.
- S_HALT: opcode_valid=0. Left only by reset.
- ctl_* inputs are sampled only on the handshake cycle and are ignored at all other times.
- Next-PC priority: ret > call > jump > skip > default (pc+2).
- All PC arithmetic is mod 4096. For example, pc=12'hFFE with skip gives 12'h002. The pc+1 fetch at 12'hFFF wraps to 12'h000.
- Stack: call writes stack[sp]=pc+2 and increments sp. ret decrements sp and reads stack[sp-1].
- Simultaneous ctl_call and ctl_ret: ret wins and no push occurs.
- fetch_addr is 12'h000 in S_CAP, S_HOLD and S_HALT.

## Timing
- Reset values: pc=RESET_PC, state=S_HI, opcode=16'h0000, opcode_valid=0, sp=0, fault=0, fetch_addr=RESET_PC.
- Latency: opcode_valid rises 3 cycles after entering S_HI. The first opcode after reset release is valid on the 3rd rising edge.
- Throughput: one opcode per 4 cycles when opcode_ready is held at 1.
- pc updates on the handshake edge. The new pc appears on fetch_addr in the next cycle (S_HI).
- Reset asserted mid-fetch or mid-hold aborts on that edge with no partial opcode retained. Stack contents need not be cleared; only sp resets.

## Configuration
- FETCH_STACK_CHECK_EN defined:
  - call with sp==16 sets fault, performs no push, and enters S_HALT.
  - ret with sp==0 sets fault and enters S_HALT.
- FETCH_STACK_CHECK_EN undefined:
  - sp wraps within 0..15 (bit 4 tied to 0); overflow overwrites stack[0] and underflow reads stack[15].
  - fault is tied to 0, and S_HALT is unreachable.

## Test plan
- Reset release with mem[200]=12, mem[201]=4E → fetch_addr 200 then 201, opcode=124E, opcode_valid on the 3rd edge, pc=200.
- Hold opcode_ready=0 for 10 cycles, then pulse it → opcode stays stable with valid=1 throughout, then pc=202 and fetch_addr=202 on the next cycle.
- Handshake with ctl_call, ctl_target=300 at pc=204 → sp=1 and pc=300. A later ctl_ret → pc=206, sp=0.
- Handshake with ctl_skip at pc=FFE → pc=002. Also, fetching at pc=FFF → fetch_addr FFF, then 000.
- Handshake with ctl_jump=1 and ctl_ret=1 and sp=1 (stack holds 208) → pc=208 (ret wins), sp=0.
- With FETCH_STACK_CHECK_EN defined, a 17th nested call → fault=1, sp=16, opcode_valid=0 permanently until resetN=0 clears everything. With it undefined → sp wraps to 0 and fault stays 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch
// Program-counter and opcode-fetch stage for a 4096-byte CHIP-8 memory.
// Reads two consecutive bytes, big-endian, to form a 16-bit opcode. It offers
// that opcode on a valid/ready handshake and applies control-flow
// dispositions (ret > call > jump > skip > pc+2) using a 16-entry return stack.
//
// Ports:
//   clock, resetN          clock; synchronous active-low reset
//   fetch_addr / fetch_byte memory address out; data returns one cycle later
//   opcode, opcode_valid, opcode_ready   opcode handshake to decode/execute
//   ctl_jump, ctl_call, ctl_ret, ctl_skip, ctl_target
//                          disposition, sampled only on the handshake cycle
//   pc, sp, fault          current pc, stack occupancy, sticky stack fault
//
// Build option: FETCH_STACK_CHECK_EN
//   defined   - overflow or underflow sets fault and parks in S_HALT
//   undefined - sp wraps within 0..15 and fault is always 0
//
// state  | meaning
// S_HI   | present pc; high byte returns next cycle
// S_LO   | present pc+1; capture high byte
// S_CAP  | capture low byte
// S_HOLD | opcode valid; wait for handshake, then update pc
// S_HALT | stack fault; left only by reset
module instruction_fetch #(
    parameter logic [11:0] RESET_PC    = 12'h200,
    parameter int          STACK_DEPTH = 16
) (
    input  logic        clock,
    input  logic        resetN,
    output logic [11:0] fetch_addr,
    input  logic [7:0]  fetch_byte,
    output logic [15:0] opcode,
    output logic        opcode_valid,
    input  logic        opcode_ready,
    input  logic        ctl_jump,
    input  logic        ctl_call,
    input  logic        ctl_ret,
    input  logic        ctl_skip,
    input  logic [11:0] ctl_target,
    output logic [11:0] pc,
    output logic [4:0]  sp,
    output logic        fault
);

    localparam logic [2:0] S_HI   = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    logic [2:0]  state, state_nxt;
    logic [11:0] pc_nxt;
    logic [4:0]  sp_nxt, sp_inc, sp_dec;
    logic        fault_q, fault_nxt;
    logic        push;
    logic [11:0] pop_val;
    logic [11:0] stack [STACK_DEPTH];

`ifdef FETCH_STACK_CHECK_EN
    assign sp_inc = sp + 5'd1;
    assign sp_dec = sp - 5'd1;
`else
    // Bit 4 stays 0 so the pointer wraps within the 16 entries.
    assign sp_inc = {1'b0, sp[3:0] + 4'd1};
    assign sp_dec = {1'b0, sp[3:0] - 4'd1};
`endif

    assign pop_val      = stack[sp_dec[3:0]];
    assign opcode_valid = (state == S_HOLD);
    assign fault        = fault_q;

    always_comb begin
        fetch_addr = 12'h000;
        case (state)
            S_HI:    fetch_addr = pc;
            S_LO:    fetch_addr = pc + 12'd1;
            default: fetch_addr = 12'h000;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        sp_nxt    = sp;
        fault_nxt = fault_q;
        push      = 1'b0;
        case (state)
            S_HI:  state_nxt = S_LO;
            S_LO:  state_nxt = S_CAP;
            S_CAP: state_nxt = S_HOLD;
            S_HOLD: begin
                if (opcode_ready) begin
                    state_nxt = S_HI;
                    if (ctl_ret) begin
`ifdef FETCH_STACK_CHECK_EN
                        if (sp == 5'd0) begin
                            fault_nxt = 1'b1;
                            state_nxt = S_HALT;
                        end else begin
                            pc_nxt = pop_val;
                            sp_nxt = sp_dec;
                        end
`else
                        pc_nxt = pop_val;
                        sp_nxt = sp_dec;
`endif
                    end else if (ctl_call) begin
`ifdef FETCH_STACK_CHECK_EN
                        if (sp == 5'd16) begin
                            fault_nxt = 1'b1;
                            state_nxt = S_HALT;
                        end else begin
                            push   = 1'b1;
                            sp_nxt = sp_inc;
                            pc_nxt = ctl_target;
                        end
`else
                        push   = 1'b1;
                        sp_nxt = sp_inc;
                        pc_nxt = ctl_target;
`endif
                    end else if (ctl_jump) begin
                        pc_nxt = ctl_target;
                    end else if (ctl_skip) begin
                        pc_nxt = pc + 12'd4;
                    end else begin
                        pc_nxt = pc + 12'd2;
                    end
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_HI;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state   <= S_HI;
            pc      <= RESET_PC;
            opcode  <= 16'h0000;
            sp      <= 5'd0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            sp      <= sp_nxt;
            fault_q <= fault_nxt;
            if (state == S_LO)
                opcode[15:8] <= fetch_byte;
            if (state == S_CAP)
                opcode[7:0] <= fetch_byte;
        end
    end

    // Stack contents survive reset; only sp is cleared.
    always_ff @(posedge clock) begin
        if (resetN && push)
            stack[sp[3:0]] <= pc + 12'd2;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        resetN;
    logic [11:0] fetch_addr;
    logic [7:0]  fetch_byte;
    logic [15:0] opcode;
    logic        opcode_valid;
    logic        opcode_ready;
    logic        ctl_jump, ctl_call, ctl_ret, ctl_skip;
    logic [11:0] ctl_target;
    logic [11:0] pc;
    logic [4:0]  sp;
    logic        fault;

    logic [7:0] mem [0:4095];
    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch #(.RESET_PC(12'h200), .STACK_DEPTH(16)) dut (
        .clock(clock), .resetN(resetN),
        .fetch_addr(fetch_addr), .fetch_byte(fetch_byte),
        .opcode(opcode), .opcode_valid(opcode_valid), .opcode_ready(opcode_ready),
        .ctl_jump(ctl_jump), .ctl_call(ctl_call), .ctl_ret(ctl_ret), .ctl_skip(ctl_skip),
        .ctl_target(ctl_target), .pc(pc), .sp(sp), .fault(fault)
    );

    always #5 clock = ~clock;

    // Memory model: one-cycle read latency.
    always @(posedge clock) fetch_byte <= mem[fetch_addr];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] op_at(input logic [11:0] a);
        logic [11:0] b;
        b = a + 12'd1;
        return {mem[a], mem[b]};
    endfunction

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!opcode_valid && n < 8) begin
            tick();
            n++;
        end
        n_checks++;
        if (!opcode_valid) $display("FAIL %s valid_timeout got=%0b want=1", tag, opcode_valid);
        else n_pass++;
    endtask

    task automatic handshake(input logic j, input logic c, input logic r, input logic s,
                             input logic [11:0] t);
        ctl_jump = j; ctl_call = c; ctl_ret = r; ctl_skip = s; ctl_target = t;
        opcode_ready = 1'b1;
        tick();
        opcode_ready = 1'b0;
        ctl_jump = 0; ctl_call = 0; ctl_ret = 0; ctl_skip = 0; ctl_target = 12'h000;
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        repeat (3) tick();
        n_checks++; if (pc !== 12'h200) $display("FAIL rst_pc got=%h want=200", pc); else n_pass++;
        n_checks++; if (opcode !== 16'h0000) $display("FAIL rst_opcode got=%h want=0000", opcode); else n_pass++;
        n_checks++; if (opcode_valid !== 1'b0) $display("FAIL rst_valid got=%b want=0", opcode_valid); else n_pass++;
        n_checks++; if (sp !== 5'd0) $display("FAIL rst_sp got=%0d want=0", sp); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL rst_fault got=%b want=0", fault); else n_pass++;
        n_checks++; if (fetch_addr !== 12'h200) $display("FAIL rst_faddr got=%h want=200", fetch_addr); else n_pass++;
        resetN = 1'b1;
        tick();
        n_checks++; if (fetch_addr !== 12'h201) $display("FAIL lat_faddr_lo got=%h want=201", fetch_addr); else n_pass++;
        n_checks++; if (opcode_valid !== 1'b0) $display("FAIL lat_valid1 got=%b want=0", opcode_valid); else n_pass++;
        tick();
        n_checks++; if (opcode_valid !== 1'b0 || fetch_addr !== 12'h000)
            $display("FAIL lat_cap got=%b/%h want=0/000", opcode_valid, fetch_addr); else n_pass++;
        tick();
        n_checks++; if (opcode_valid !== 1'b1) $display("FAIL lat_valid3 got=%b want=1", opcode_valid); else n_pass++;
        n_checks++; if (opcode !== 16'h124E) $display("FAIL first_opcode got=%h want=124e", opcode); else n_pass++;
        n_checks++; if (pc !== 12'h200) $display("FAIL first_pc got=%h want=200", pc); else n_pass++;
    endtask

    task automatic test_hold;
        // A disposition presented without ready must be ignored.
        ctl_jump = 1'b1; ctl_target = 12'hABC; opcode_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (opcode_valid !== 1'b1 || opcode !== 16'h124E || pc !== 12'h200)
                $display("FAIL hold_stable[%0d] got=%b/%h/%h want=1/124e/200", i, opcode_valid, opcode, pc);
            else n_pass++;
        end
        ctl_jump = 1'b0; ctl_target = 12'h000;
        handshake(0, 0, 0, 0, 12'h000);
        n_checks++; if (pc !== 12'h202) $display("FAIL hold_next_pc got=%h want=202", pc); else n_pass++;
        n_checks++; if (fetch_addr !== 12'h202) $display("FAIL hold_next_faddr got=%h want=202", fetch_addr); else n_pass++;
        n_checks++; if (opcode_valid !== 1'b0) $display("FAIL hold_drop_valid got=%b want=0", opcode_valid); else n_pass++;
    endtask

    task automatic test_call_ret;
        wait_valid("cr0");
        handshake(0, 0, 0, 0, 12'h000);
        wait_valid("cr1");
        n_checks++; if (pc !== 12'h204) $display("FAIL cr_pc204 got=%h want=204", pc); else n_pass++;
        n_checks++; if (opcode !== op_at(12'h204)) $display("FAIL cr_op204 got=%h want=%h", opcode, op_at(12'h204)); else n_pass++;
        handshake(0, 1, 0, 0, 12'h300);
        n_checks++; if (pc !== 12'h300 || sp !== 5'd1) $display("FAIL call got=%h/%0d want=300/1", pc, sp); else n_pass++;
        wait_valid("cr2");
        n_checks++; if (opcode !== op_at(12'h300)) $display("FAIL cr_op300 got=%h want=%h", opcode, op_at(12'h300)); else n_pass++;
        handshake(0, 0, 1, 0, 12'h000);
        n_checks++; if (pc !== 12'h206 || sp !== 5'd0) $display("FAIL ret got=%h/%0d want=206/0", pc, sp); else n_pass++;
    endtask

    task automatic test_ret_priority;
        wait_valid("rp0");
        handshake(0, 1, 0, 0, 12'h300);
        n_checks++; if (sp !== 5'd1) $display("FAIL rp_push got=%0d want=1", sp); else n_pass++;
        wait_valid("rp1");
        handshake(1, 0, 1, 1, 12'h123);
        n_checks++; if (pc !== 12'h208 || sp !== 5'd0) $display("FAIL ret_wins got=%h/%0d want=208/0", pc, sp); else n_pass++;
        wait_valid("rp2");
        handshake(1, 0, 0, 1, 12'h456);
        n_checks++; if (pc !== 12'h456) $display("FAIL jump_over_skip got=%h want=456", pc); else n_pass++;
    endtask

    task automatic test_wrap;
        wait_valid("w0");
        handshake(1, 0, 0, 0, 12'hFFE);
        wait_valid("w1");
        n_checks++; if (opcode !== op_at(12'hFFE)) $display("FAIL op_ffe got=%h want=%h", opcode, op_at(12'hFFE)); else n_pass++;
        handshake(0, 0, 0, 1, 12'h000);
        n_checks++; if (pc !== 12'h002) $display("FAIL skip_wrap got=%h want=002", pc); else n_pass++;
        wait_valid("w2");
        handshake(1, 0, 0, 0, 12'hFFF);
        n_checks++; if (fetch_addr !== 12'hFFF) $display("FAIL faddr_fff got=%h want=fff", fetch_addr); else n_pass++;
        tick();
        n_checks++; if (fetch_addr !== 12'h000) $display("FAIL faddr_wrap got=%h want=000", fetch_addr); else n_pass++;
        wait_valid("w3");
        n_checks++; if (opcode !== op_at(12'hFFF)) $display("FAIL op_fff got=%h want=%h", opcode, op_at(12'hFFF)); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int nvalid;
        nvalid = 0;
        opcode_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (opcode_valid) nvalid++;
        end
        opcode_ready = 1'b0;
        n_checks++; if (nvalid != 2) $display("FAIL b2b_count got=%0d want=2", nvalid); else n_pass++;
        n_checks++; if (pc !== 12'h003) $display("FAIL b2b_pc got=%h want=003", pc); else n_pass++;
        n_checks++; if (opcode !== op_at(12'h003)) $display("FAIL b2b_op got=%h want=%h", opcode, op_at(12'h003)); else n_pass++;
    endtask

    task automatic test_overflow;
        logic bad;
        for (int i = 0; i < 16; i++) begin
            wait_valid("ov");
            handshake(0, 1, 0, 0, 12'h300);
        end
`ifdef FETCH_STACK_CHECK_EN
        n_checks++; if (sp !== 5'd16 || fault !== 1'b0) $display("FAIL ov16 got=%0d/%b want=16/0", sp, fault); else n_pass++;
`else
        n_checks++; if (sp !== 5'd0 || fault !== 1'b0) $display("FAIL ov16 got=%0d/%b want=0/0", sp, fault); else n_pass++;
`endif
        wait_valid("ov17");
        handshake(0, 1, 0, 0, 12'h300);
`ifdef FETCH_STACK_CHECK_EN
        n_checks++; if (fault !== 1'b1 || sp !== 5'd16) $display("FAIL ov17 got=%b/%0d want=1/16", fault, sp); else n_pass++;
        bad = 1'b0;
        opcode_ready = 1'b1;
        repeat (8) begin
            tick();
            if (opcode_valid !== 1'b0 || fetch_addr !== 12'h000) bad = 1'b1;
        end
        opcode_ready = 1'b0;
        n_checks++; if (bad !== 1'b0) $display("FAIL halt_stuck got=%b want=0", bad); else n_pass++;
`else
        n_checks++; if (fault !== 1'b0 || sp !== 5'd1) $display("FAIL ov17 got=%b/%0d want=0/1", fault, sp); else n_pass++;
        wait_valid("ov18");
        bad = (opcode !== op_at(12'h300));
        n_checks++; if (bad !== 1'b0) $display("FAIL ov_op got=%h want=%h", opcode, op_at(12'h300)); else n_pass++;
`endif
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        n_checks++;
        if (fault !== 1'b0 || sp !== 5'd0 || pc !== 12'h200 || opcode_valid !== 1'b0 || opcode !== 16'h0000)
            $display("FAIL final_reset got=%b/%0d/%h/%b/%h want=0/0/200/0/0000", fault, sp, pc, opcode_valid, opcode);
        else n_pass++;
        wait_valid("post_rst");
        n_checks++; if (opcode !== 16'h124E) $display("FAIL post_rst_op got=%h want=124e", opcode); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 7 + 3) ^ (i >> 4));
        mem[12'h200] = 8'h12;
        mem[12'h201] = 8'h4E;
        resetN = 1'b0; opcode_ready = 1'b0;
        ctl_jump = 0; ctl_call = 0; ctl_ret = 0; ctl_skip = 0; ctl_target = 12'h000;
        test_reset();
        test_hold();
        test_call_ret();
        test_ret_priority();
        test_wrap();
        test_back_to_back();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
